// File: rtl/bit_serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell plus a registered borrow, LSB first.
// Optional signed-overflow output enabled by defining BIT_SERIAL_SUB_OVF_EN.
module bit_serial_sub #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             brw
`ifdef BIT_SERIAL_SUB_OVF_EN
   ,output logic            ovf
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             brw_q, brw_d;
`ifdef BIT_SERIAL_SUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic cell_x, cell_y, cell_c, cell_d, cell_bo, last_bit;

   // Full-subtractor cell fed from the shift-register LSBs and the stored borrow.
   always_comb begin
      cell_x   = a_sr_q[0];
      cell_y   = b_sr_q[0];
      cell_c   = borrow_q;
      cell_d   = cell_x ^ cell_y ^ cell_c;
      cell_bo  = (~cell_x & cell_y) | (~cell_x & cell_c) | (cell_y & cell_c);
      last_bit = (cnt_q == CNT_W'(WIDTH - 1));
   end

   // NOTE: every variable gets a hold default first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      res_d    = res_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      brw_d    = brw_q;
`ifdef BIT_SERIAL_SUB_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_sr_d   = a;
               b_sr_d   = b;
               borrow_d = bin;
               cnt_d    = '0;
               state_d  = ST_RUN;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RUN: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            res_d    = {cell_d, res_q[WIDTH-1:1]};
            borrow_d = cell_bo;
            if (last_bit) begin
               // Counter parks at WIDTH-1; it is reloaded on the next accept.
               diff_d  = {cell_d, res_q[WIDTH-1:1]};
               brw_d   = cell_bo;
`ifdef BIT_SERIAL_SUB_OVF_EN
               ovf_d   = cell_c ^ cell_bo;
`endif
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         brw_q    <= 1'b0;
`ifdef BIT_SERIAL_SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         brw_q    <= brw_d;
`ifdef BIT_SERIAL_SUB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign diff = diff_q;
   assign brw  = brw_q;
`ifdef BIT_SERIAL_SUB_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_sub.sv
// Self-checking bench for bit_serial_sub: per-cycle arithmetic model on an 8-bit
// instance, directed literal checks, and an exhaustive sweep of a 2-bit instance.
module tb_bit_serial_sub;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, bin;
   logic [7:0] a, b;
   logic       busy, done, brw;
   logic [7:0] diff;
   logic       start2, bin2;
   logic [1:0] a2, b2;
   logic       busy2, done2, brw2;
   logic [1:0] diff2;
`ifdef BIT_SERIAL_SUB_OVF_EN
   logic       ovf, ovf2;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bit_serial_sub #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .brw(brw)
`ifdef BIT_SERIAL_SUB_OVF_EN
      , .ovf(ovf)
`endif
   );

   bit_serial_sub #(.WIDTH(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
      .busy(busy2), .done(done2), .diff(diff2), .brw(brw2)
`ifdef BIT_SERIAL_SUB_OVF_EN
      , .ovf(ovf2)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic model of the 8-bit instance: an accepted start yields its answer
   // eight edges later; starts while an operation is pending are dropped.
   int         m_left = 0;
   logic       m_done = 1'b0;
   logic [7:0] m_diff = '0, p_diff = '0;
   logic       m_brw = 1'b0, p_brw = 1'b0;
   logic       m_ovf = 1'b0, p_ovf = 1'b0;
   logic       chk_en = 1'b0;

   always @(posedge clk) begin
      int r, sr;
      if (!rst_n) begin
         m_left = 0;
         m_done = 1'b0;
         m_diff = '0;
         m_brw  = 1'b0;
         m_ovf  = 1'b0;
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         m_done = (m_left == 0);
         if (m_left == 0) begin
            m_diff = p_diff;
            m_brw  = p_brw;
            m_ovf  = p_ovf;
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            r      = int'(a) - int'(b) - int'(bin);
            sr     = int'($signed(a)) - int'($signed(b)) - int'(bin);
            p_diff = r[7:0];
            p_brw  = (r < 0);
            p_ovf  = (sr < -128) || (sr > 127);
            m_left = 8;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 32'(busy), 32'(m_left > 0));
         check("done", 32'(done), 32'(m_done));
         check("diff", 32'(diff), 32'(m_diff));
         check("brw",  32'(brw),  32'(m_brw));
`ifdef BIT_SERIAL_SUB_OVF_EN
         check("ovf",  32'(ovf),  32'(m_ovf));
`endif
      end
   end

   // Issue one op on the 8-bit instance and watch a fixed window after it.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         output int busy_cyc, output int lat, output int pulses);
      @(negedge clk);
      a = ta; b = tb; bin = tbin; start = 1'b1;
      busy_cyc = 0; lat = 0; pulses = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) busy_cyc++;
         if (done) begin
            pulses++;
            if (lat == 0) lat = i;
         end
      end
   endtask

   initial begin
      int bc, lat, np;
      bit got;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_diff", 32'(diff), 32'd0);
      rst_n = 1'b1;

      // 5 - 3
      run_op(8'h05, 8'h03, 1'b0, bc, lat, np);
      check("t1_busy_cycles", bc, 8);
      check("t1_latency", lat, 9);
      check("t1_pulses", np, 1);
      check("t1_diff", 32'(diff), 32'h02);
      check("t1_brw", 32'(brw), 32'd0);
`ifdef BIT_SERIAL_SUB_OVF_EN
      check("t1_ovf", 32'(ovf), 32'd0);
`endif

      run_op(8'h03, 8'h05, 1'b0, bc, lat, np);
      check("t2_diff", 32'(diff), 32'hFE);
      check("t2_brw", 32'(brw), 32'd1);

      run_op(8'h00, 8'h00, 1'b1, bc, lat, np);
      check("t3_diff", 32'(diff), 32'hFF);
      check("t3_brw", 32'(brw), 32'd1);

      run_op(8'h5A, 8'h5A, 1'b0, bc, lat, np);
      check("t4_diff", 32'(diff), 32'h00);
      check("t4_brw", 32'(brw), 32'd0);

`ifdef BIT_SERIAL_SUB_OVF_EN
      run_op(8'h80, 8'h01, 1'b0, bc, lat, np);
      check("ovf_diff", 32'(diff), 32'h7F);
      check("ovf_brw", 32'(brw), 32'd0);
      check("ovf_set", 32'(ovf), 32'd1);
`endif

      // Second start at cycle 3 while busy must be ignored.
      @(negedge clk);
      a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); a = 8'hFF; b = 8'hFF; start = 1'b1;
      @(negedge clk); start = 1'b0;
      np = 0; got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         @(negedge clk);
         if (done) begin
            np++;
            got = 1'b1;
         end
      end
      check("ign_done_seen", 32'(got), 32'd1);
      check("ign_diff", 32'(diff), 32'h0F);
      check("ign_brw", 32'(brw), 32'd0);
      // Start asserted in the DONE cycle is accepted.
      a = 8'h20; b = 8'h01; start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("done_accept_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) np++;
      end
      check("ign_pulses", np, 2);
      check("done_accept_diff", 32'(diff), 32'h1F);

      // Reset mid-operation aborts it.
      @(negedge clk);
      a = 8'hAA; b = 8'h55; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(diff), 32'h00);
      check("rst_brw", 32'(brw), 32'd0);
      rst_n = 1'b1;
      np = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) np++;
      end
      check("rst_no_pulse", np, 0);
      run_op(8'h0A, 8'h03, 1'b0, bc, lat, np);
      check("post_rst_diff", 32'(diff), 32'h07);
      check("post_rst_pulses", np, 1);

      // Exhaustive 2-bit sweep.
      for (int ia = 0; ia < 4; ia++) begin
         for (int ib = 0; ib < 4; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               int r;
               @(negedge clk);
               a2 = 2'(ia); b2 = 2'(ib); bin2 = 1'(ic); start2 = 1'b1;
               @(negedge clk); start2 = 1'b0;
               got = 1'b0;
               for (int t = 0; t < 8 && !got; t++) begin
                  @(negedge clk);
                  if (done2) got = 1'b1;
               end
               r = ia - ib - ic;
               check("w2_done", 32'(got), 32'd1);
               check("w2_diff", 32'(diff2), 32'(r & 3));
               check("w2_brw", 32'(brw2), 32'(ia < ib + ic));
            end
         end
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
